// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_adder_ctrl                                                |
// | Brief   : Bit-serial WIDTH-bit adder, one full-adder cell, start/busy/done |
// |           handshake. Define SERIAL_SUB_EN to add the sub_i (a - b) port.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;
    logic             w_cell_s;
    logic             w_cell_co;
    logic [WIDTH-1:0] w_part_shift;
    logic             w_last;

`ifdef SERIAL_SUB_EN
    // Subtraction is a + ~b + 1: invert B on load and preset the carry.
    assign w_b_load     = sub_i ? ~b_i : b_i;
    assign w_carry_load = sub_i ? 1'b1 : cin_i;
`else
    assign w_b_load     = b_i;
    assign w_carry_load = cin_i;
`endif

    assign w_cell_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_cell_co    = ((a_q[0] ^ b_q[0]) & carry_q) | (a_q[0] & b_q[0]);
    assign w_part_shift = {w_cell_s, part_q[WIDTH-1:1]};
    assign w_last       = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = a_i;
                    b_d     = w_b_load;
                    carry_d = w_carry_load;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                part_d  = w_part_shift;
                carry_d = w_cell_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (w_last) begin
                    // Results only move on this edge so no partial sum is ever visible.
                    state_d = S_DONE;
                    sum_d   = w_part_shift;
                    cout_d  = w_cell_co;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_serial_adder_ctrl                                             |
// | Brief   : Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=5.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = '0;
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];
    logic [1:0] cin_v = '0;
    logic [1:0] sub_v = '0;

    logic       busy8, done8, cout8, busy5, done5, cout5;
    logic [7:0] sum8;
    logic [4:0] sum5;
    logic [1:0] busy_w, done_w, cout_w;
    logic [7:0] sum_w [2];

    assign busy_w   = {busy5, busy8};
    assign done_w   = {done5, done8};
    assign cout_w   = {cout5, cout8};
    assign sum_w[0] = sum8;
    assign sum_w[1] = {3'b000, sum5};

    int n_err = 0;
    int n_chk = 0;
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [1:0] prev_done = '0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start_v[0]),
        .a_i(a_v[0]), .b_i(b_v[0]), .cin_i(cin_v[0]),
`ifdef SERIAL_SUB_EN
        .sub_i(sub_v[0]),
`endif
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );

    serial_adder_ctrl #(.WIDTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .start_i(start_v[1]),
        .a_i(a_v[1][4:0]), .b_i(b_v[1][4:0]), .cin_i(cin_v[1]),
`ifdef SERIAL_SUB_EN
        .sub_i(sub_v[1]),
`endif
        .busy_o(busy5), .done_o(done5), .sum_o(sum5), .cout_o(cout5)
    );

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    // Reference: plain integer arithmetic, result packed as {cout, sum}.
    function automatic logic [8:0] model(input int d, input logic [7:0] av, input logic [7:0] bv,
                                         input logic ci, input logic sb);
        int unsigned w = wid(d);
        int unsigned m = (32'd1 << w) - 1;
        int unsigned s;
        logic        co;
        if (sb) begin
            s  = (int'(av) - int'(bv)) & m;
            co = (av >= bv);
        end else begin
            s  = int'(av) + int'(bv) + int'(ci);
            co = s[w];
            s  = s & m;
        end
        return {co, s[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done_w[d] === 1'b1) begin
                logic [8:0] exp;
                logic [8:0] got;
                got = {cout_w[d], sum_w[d]};
                chk($sformatf("done_pulse_d%0d", d), {31'd0, prev_done[d]}, 32'd0);
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done_d%0d: got done=1 expected no pending op", d);
                end else begin
                    exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("result_d%0d", d), {23'd0, got}, {23'd0, exp});
                end
            end
            prev_done[d] = done_w[d];
        end
    end

    // Issue one op at the current negedge; returns at the negedge of the DONE cycle,
    // so an immediate second call is a back-to-back start.
    task automatic op(input int d, input logic [7:0] av_in, input logic [7:0] bv_in,
                      input logic ci, input logic sb, input logic [15:0] junk);
        int w = wid(d);
        logic [7:0] m = 8'((32'd1 << w) - 1);
        logic [7:0] av = av_in & m;
        logic [7:0] bv = bv_in & m;
        int k;
        int nbusy;
        start_v[d] = 1'b1;
        a_v[d]     = av;
        b_v[d]     = bv;
        cin_v[d]   = ci;
        sub_v[d]   = sb;
        if (d == 0) q0.push_back(model(d, av, bv, ci, sb));
        else        q1.push_back(model(d, av, bv, ci, sb));
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        k = 1;
        nbusy = 0;
        while (done_w[d] !== 1'b1 && k <= w + 3) begin
            if (busy_w[d] === 1'b1) nbusy++;
            if (junk[k] && busy_w[d] === 1'b1) begin
                start_v[d] = 1'b1;
                a_v[d]     = 8'($urandom);
                b_v[d]     = 8'($urandom);
                cin_v[d]   = 1'($urandom);
            end else begin
                start_v[d] = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start_v[d] = 1'b0;
        chk($sformatf("latency_d%0d", d), k, w + 1);
        chk($sformatf("busy_cycles_d%0d", d), nbusy, w);
        chk($sformatf("busy_in_done_d%0d", d), {31'd0, busy_w[d]}, 32'd0);
    endtask

    task automatic random_sweep(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            logic sb;
`ifdef SERIAL_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            op(d, 8'($urandom), 8'($urandom), 1'($urandom), sb, 16'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_v[0] = '0; a_v[1] = '0; b_v[0] = '0; b_v[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {30'd0, busy_w}, 32'd0);
        chk("reset_done", {30'd0, done_w}, 32'd0);
        chk("reset_sum8", {24'd0, sum8}, 32'd0);
        chk("reset_sum5", {27'd0, sum5}, 32'd0);
        chk("reset_cout", {30'd0, cout_w}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 16'h0000);
        chk("add_5A_3C", {23'd0, cout8, sum8}, 32'h096);
        @(negedge clk);
        op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0000);
        chk("add_FF_FF_c1", {23'd0, cout8, sum8}, 32'h1FF);
        @(negedge clk);
        // Starts in RUN cycles 3 and 5 must be dropped, then a back-to-back start.
        op(0, 8'h21, 8'h43, 1'b0, 1'b0, 16'h0028);
        op(0, 8'h01, 8'h02, 1'b0, 1'b0, 16'h0000);
        chk("b2b_sum", {24'd0, sum8}, 32'h03);
        @(negedge clk);

        // Abort in RUN cycle 4.
        start_v[0] = 1'b1; a_v[0] = 8'h77; b_v[0] = 8'h11; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_sum", {24'd0, sum8}, 32'd0);
        chk("abort_cout", {31'd0, cout8}, 32'd0);
        // Reset held while start is presented: reset must win.
        start_v[0] = 1'b1;
        @(negedge clk);
        chk("rst_over_start", {31'd0, busy8}, 32'd0);
        rst = 1'b0;
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);
        op(0, 8'h10, 8'h20, 1'b0, 1'b0, 16'h0000);
        chk("post_abort_sum", {23'd0, cout8, sum8}, 32'h030);
        @(negedge clk);

`ifdef SERIAL_SUB_EN
        op(0, 8'h10, 8'h01, 1'b1, 1'b1, 16'h0000);
        chk("sub_10_01", {23'd0, cout8, sum8}, 32'h10F);
        @(negedge clk);
        op(0, 8'h01, 8'h02, 1'b0, 1'b1, 16'h0000);
        chk("sub_01_02", {23'd0, cout8, sum8}, 32'h0FF);
        @(negedge clk);
`endif

        fork
            random_sweep(0, 1000);
            random_sweep(1, 1000);
        join
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q0.size() + q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
